siren_light_bar: RTL and testbench
==================================

# siren_light_bar

Light-bar and tone sequencer for the police siren demo. Sits directly downstream of the siren clock divider: it consumes that divider's slow square wave (`tick_in`) and steps through red/blue LED patterns on each edge of it. It also produces a two-pitch square-wave tone for a buzzer. Everything runs in the board clock domain.

## Interface
- `TONE_HI_DIV`, default 56818: board-clock cycles per half-period of the high tone (about 1.1 kHz at 125 MHz).
- `TONE_LO_DIV`, default 113636: board-clock cycles per half-period of the low tone (about 550 Hz).
- Legal range: 2 ≤ `TONE_HI_DIV` ≤ `TONE_LO_DIV`. The tone counter is `$clog2(TONE_LO_DIV)` bits wide.

Ports:
- `clk`  in  1: board clock. One clock only.
- `rst`  in  1: reset, synchronous and active-high.
- `en`  in  1: master enable. Low forces all outputs dark and silent.
- `tick_in`  in  1: slow toggle from the siren clock divider. Every edge of it, rising or falling, is one step.
- `mode`  in  2: 00 OFF, 01 ALTERNATE, 10 CHASE, 11 STEADY.
- `led_red`  out  4: red bank.
- `led_blue`  out  4: blue bank.
- `tone`  out  1: buzzer square wave.
- `phase`  out  1: current pattern half. 0 = A (red/high), 1 = B (blue/low).

## Operation
State registers:
- `tick_q`: last sample of `tick_in`.
- `mode_q`: last sample of `mode`.
- `phase`.
- `pos`: 3-bit chase position.
- `tcnt`: tone counter.
- `tone`.
- `sel_q`: last tone select.

Step and change detection:
- `step = tick_in ^ tick_q`.
- `mchg = (mode != mode_q)`.
- `tick_q` and `mode_q` load every cycle.

Priority at each clock edge, highest first:
1. `rst`: `tick_q<=tick_in`, `mode_q<=mode`, `phase<=0`, `pos<=0`, `tcnt<=0`, `tone<=0`, `sel_q<=0`. Because `tick_q` loads `tick_in`, no spurious step occurs after reset.
2. `en`=0: `phase<=0`, `pos<=0`, `tcnt<=0`, `tone<=0`. Outputs are all zero.
3. `mchg`: `phase<=0`, `pos<=0`, `tcnt<=0`. `tone` holds its level. A step in the same cycle is discarded.
4. `step`: `phase<=~phase`, `pos<=pos+1` (wraps 7→0).

LED decode is combinational from registered state and current `mode_q`:
- OFF: red=0000, blue=0000.
- ALTERNATE: phase A gives red=1111, blue=0000. Phase B gives red=0000, blue=1111.
- CHASE: `pos` 0–3 lights only `led_red[pos]`. `pos` 4–7 lights only `led_blue[pos-4]`. So one LED is lit, sweeping red0..red3 then blue0..blue3.
- STEADY: red=1111, blue=1111.
- `en`=0 overrides everything to 0000/0000.

Tone:
- Tone select `sel` = high or low:
  - ALTERNATE: high in phase A, low in phase B.
  - CHASE: high when `pos`<4, low otherwise.
  - STEADY: always high.
- OFF or `en`=0: `tone` held at 0 and `tcnt` held at 0.
- Otherwise `tcnt` increments each cycle. When `tcnt == DIV-1` for the selected divider, `tone` toggles and `tcnt<=0`.
- When `sel != sel_q`, `tcnt<=0` and `tone` holds. `sel_q` loads `sel` every cycle.
- Tone half-period is exactly DIV cycles in steady state.

`phase` output is registered state. In OFF and STEADY it is still updated by steps.

## Timing
- Reset values: `led_red`=0, `led_blue`=0, `tone`=0, `phase`=0.
- Step latency: if `tick_in` changes between edges k-1 and k, `phase`/`pos` update at edge k, and the LEDs reflect the new state right after edge k. Latency is 1 edge.
- Consecutive `tick_in` changes on consecutive cycles each count as one step. No minimum spacing is required.
- Mode latency: a new `mode` value presented before edge k updates `mode_q` at edge k. LED decode switches after edge k with `phase=0` and `pos=0`.
- `en` falling: outputs are 0 after the next edge. `en` rising: state starts from A/0, tone starts at 0, and the first tone toggle comes DIV cycles later.
- `rst` mid-pattern takes effect at the next edge regardless of `en`, `mode` or `step`.
- Tone: the first toggle comes DIV cycles after `tcnt` is cleared.

## Test plan
Tests use `TONE_HI_DIV`=4 and `TONE_LO_DIV`=8.
1. Reset with `tick_in`=1, then release with `mode`=01, `en`=1, `tick_in` held at 1. Required: no step; red=1111, blue=0000, `phase`=0; `tone` toggles every 4 cycles.
2. ALTERNATE: toggle `tick_in` 3 times, 20 cycles apart. Required: `phase` goes 1,0,1, each change one edge after the `tick_in` change. Blue=1111 in phase B. Tone half-period goes 4→8→4→8, and `tcnt` restarts at each change.
3. CHASE: 9 steps. Required: LED sequence red0, red1, red2, red3, blue0, blue1, blue2, blue3, red0 (wrap). Tone is high for the first four positions and low for the next four.
4. Mode change to STEADY in the same cycle as a `tick_in` edge. Required: the step is discarded, `phase`=0, red=blue=1111, and the tone half-period is 4.
5. `en` dropped mid-CHASE at `pos`=5. Required: red=blue=0000 and `tone`=0 after the next edge. After `en` returns, the pattern restarts at red0.
6. `rst` asserted for 1 cycle mid-ALTERNATE in phase B with `tone`=1. Required: all outputs 0 and `phase`=0 after that edge, and a 1→0 `tick_in` change during reset produces no later step.

Source files
------------

// File: rtl/siren_light_bar.sv
// Red/blue light-bar pattern sequencer and two-pitch buzzer tone generator.
// Each edge of tick_in advances the pattern by one step.
module siren_light_bar #(
  parameter int unsigned TONE_HI_DIV = 56818,
  parameter int unsigned TONE_LO_DIV = 113636
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       tick_in,
  input  logic [1:0] mode,
  output logic [3:0] led_red,
  output logic [3:0] led_blue,
  output logic       tone,
  output logic       phase
);

  localparam int unsigned CntW = $clog2(TONE_LO_DIV);
  localparam logic [CntW-1:0] HiLast = CntW'(TONE_HI_DIV - 1);
  localparam logic [CntW-1:0] LoLast = CntW'(TONE_LO_DIV - 1);

  typedef enum logic [1:0] {
    ModeOff    = 2'b00,
    ModeAlt    = 2'b01,
    ModeChase  = 2'b10,
    ModeSteady = 2'b11
  } mode_e;

  logic            tick_q;
  mode_e           mode_q;
  logic            phase_q, phase_d;
  logic [2:0]      pos_q, pos_d;
  logic [CntW-1:0] tcnt_q, tcnt_d;
  logic            tone_q, tone_d;
  logic            sel_q;

  logic            step;
  logic            mchg;
  logic            sel;       // 0 = high tone, 1 = low tone
  logic [CntW-1:0] tcnt_last;

  always_comb begin
    step = tick_in ^ tick_q;
    mchg = (mode != mode_q);

    unique case (mode_q)
      ModeAlt:   sel = phase_q;
      ModeChase: sel = pos_q[2];
      default:   sel = 1'b0;
    endcase
    tcnt_last = sel ? LoLast : HiLast;

    phase_d = phase_q;
    pos_d   = pos_q;
    tcnt_d  = tcnt_q;
    tone_d  = tone_q;

    if (!en) begin
      phase_d = 1'b0;
      pos_d   = 3'd0;
      tcnt_d  = '0;
      tone_d  = 1'b0;
    end else if (mchg) begin
      // Restart the pattern; any step arriving with the mode change is dropped.
      phase_d = 1'b0;
      pos_d   = 3'd0;
      tcnt_d  = '0;
    end else begin
      if (step) begin
        phase_d = ~phase_q;
        pos_d   = pos_q + 3'd1;
      end
      if (mode_q == ModeOff) begin
        tcnt_d = '0;
        tone_d = 1'b0;
      end else if (sel != sel_q) begin
        tcnt_d = '0;
      end else if (tcnt_q == tcnt_last) begin
        tcnt_d = '0;
        tone_d = ~tone_q;
      end else begin
        tcnt_d = tcnt_q + 1'b1;
      end
    end
  end

  // tick_q loads tick_in even in reset so no spurious step follows release.
  always_ff @(posedge clk) begin
    tick_q <= tick_in;
    mode_q <= mode_e'(mode);
    if (rst) begin
      phase_q <= 1'b0;
      pos_q   <= 3'd0;
      tcnt_q  <= '0;
      tone_q  <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      pos_q   <= pos_d;
      tcnt_q  <= tcnt_d;
      tone_q  <= tone_d;
      sel_q   <= sel;
    end
  end

  always_comb begin
    led_red  = 4'b0000;
    led_blue = 4'b0000;
    if (en && !rst) begin
      unique case (mode_q)
        ModeOff: ;
        ModeAlt: begin
          if (phase_q) led_blue = 4'b1111;
          else         led_red  = 4'b1111;
        end
        ModeChase: begin
          if (pos_q[2]) led_blue = 4'b0001 << pos_q[1:0];
          else          led_red  = 4'b0001 << pos_q[1:0];
        end
        ModeSteady: begin
          led_red  = 4'b1111;
          led_blue = 4'b1111;
        end
      endcase
    end
  end

  assign tone  = tone_q;
  assign phase = phase_q;

endmodule

// File: tb/tb_siren_light_bar.sv
// Directed bench for siren_light_bar with tone dividers 4 (high) and 8 (low).
module tb_siren_light_bar;

  logic       clk;
  logic       rst;
  logic       en;
  logic       tick_in;
  logic [1:0] mode;
  logic [3:0] led_red;
  logic [3:0] led_blue;
  logic       tone;
  logic       phase;

  int n_vec = 0;
  int n_err = 0;

  siren_light_bar #(
    .TONE_HI_DIV(4),
    .TONE_LO_DIV(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .tick_in (tick_in),
    .mode    (mode),
    .led_red (led_red),
    .led_blue(led_blue),
    .tone    (tone),
    .phase   (phase)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1);
  end

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  // Returns the tone half-period in cycles, or -1 if the tone stopped toggling.
  task automatic measure_half(output int n);
    logic t0;
    int   guard;
    n     = -1;
    t0    = tone;
    guard = 0;
    while (tone === t0 && guard < 40) begin
      step_clk();
      guard++;
    end
    if (tone === t0) return;
    t0 = tone;
    n  = 0;
    while (tone === t0 && n < 40) begin
      step_clk();
      n++;
    end
    if (tone === t0) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 2'b01; tick_in = 1'b1;
    step_clk();
    step_clk();
    n_vec++; if (led_red !== 4'b0000) begin n_err++; $display("FAIL rst_red got %b want 0000", led_red); end
    n_vec++; if (led_blue !== 4'b0000) begin n_err++; $display("FAIL rst_blue got %b want 0000", led_blue); end
    n_vec++; if (tone !== 1'b0) begin n_err++; $display("FAIL rst_tone got %b want 0", tone); end
    n_vec++; if (phase !== 1'b0) begin n_err++; $display("FAIL rst_phase got %b want 0", phase); end
    rst = 1'b0;
    step_clk();
    n_vec++; if (led_red !== 4'b1111) begin n_err++; $display("FAIL rel_red got %b want 1111", led_red); end
    n_vec++; if (led_blue !== 4'b0000) begin n_err++; $display("FAIL rel_blue got %b want 0000", led_blue); end
    n_vec++; if (phase !== 1'b0) begin n_err++; $display("FAIL rel_phase got %b want 0", phase); end
    step_clk();
    step_clk();
    n_vec++; if (tone !== 1'b0) begin n_err++; $display("FAIL rel_tone3 got %b want 0", tone); end
    step_clk();
    n_vec++; if (tone !== 1'b1) begin n_err++; $display("FAIL rel_tone4 got %b want 1", tone); end
    repeat (4) step_clk();
    n_vec++; if (tone !== 1'b0) begin n_err++; $display("FAIL rel_tone8 got %b want 0", tone); end
    n_vec++; if (phase !== 1'b0) begin n_err++; $display("FAIL rel_nostep got %b want 0", phase); end
  endtask

  task automatic test_alternate();
    logic exp_ph;
    int   half;
    for (int i = 0; i < 3; i++) begin
      exp_ph  = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick_in = ~tick_in;
      #1;
      n_vec++; if (phase !== ~exp_ph) begin n_err++; $display("FAIL alt_pre%0d got %b want %b", i, phase, ~exp_ph); end
      step_clk();
      n_vec++; if (phase !== exp_ph) begin n_err++; $display("FAIL alt_phase%0d got %b want %b", i, phase, exp_ph); end
      n_vec++; if (led_red !== (exp_ph ? 4'b0000 : 4'b1111)) begin n_err++; $display("FAIL alt_red%0d got %b", i, led_red); end
      n_vec++; if (led_blue !== (exp_ph ? 4'b1111 : 4'b0000)) begin n_err++; $display("FAIL alt_blue%0d got %b", i, led_blue); end
      measure_half(half);
      n_vec++; if (half !== (exp_ph ? 8 : 4)) begin n_err++; $display("FAIL alt_half%0d got %0d want %0d", i, half, exp_ph ? 8 : 4); end
    end
  endtask

  task automatic test_chase();
    logic [3:0] exp_red  [9];
    logic [3:0] exp_blue [9];
    int half;
    exp_red  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
    exp_blue = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    mode = 2'b10;
    step_clk();
    n_vec++; if (phase !== 1'b0) begin n_err++; $display("FAIL chase_phase0 got %b want 0", phase); end
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin
        tick_in = ~tick_in;
        step_clk();
      end
      n_vec++; if (led_red !== exp_red[i]) begin n_err++; $display("FAIL chase_red%0d got %b want %b", i, led_red, exp_red[i]); end
      n_vec++; if (led_blue !== exp_blue[i]) begin n_err++; $display("FAIL chase_blue%0d got %b want %b", i, led_blue, exp_blue[i]); end
      if (i == 0 || i == 4) begin
        measure_half(half);
        n_vec++; if (half !== (i == 0 ? 4 : 8)) begin n_err++; $display("FAIL chase_half%0d got %0d want %0d", i, half, i == 0 ? 4 : 8); end
      end
    end
  endtask

  task automatic test_enable();
    for (int i = 0; i < 5; i++) begin
      tick_in = ~tick_in;
      step_clk();
    end
    n_vec++; if (led_blue !== 4'b0010) begin n_err++; $display("FAIL en_pos5 got %b want 0010", led_blue); end
    en = 1'b0;
    step_clk();
    n_vec++; if (led_red !== 4'b0000) begin n_err++; $display("FAIL en_off_red got %b want 0000", led_red); end
    n_vec++; if (led_blue !== 4'b0000) begin n_err++; $display("FAIL en_off_blue got %b want 0000", led_blue); end
    n_vec++; if (tone !== 1'b0) begin n_err++; $display("FAIL en_off_tone got %b want 0", tone); end
    n_vec++; if (phase !== 1'b0) begin n_err++; $display("FAIL en_off_phase got %b want 0", phase); end
    repeat (3) step_clk();
    en = 1'b1;
    step_clk();
    n_vec++; if (led_red !== 4'b0001) begin n_err++; $display("FAIL en_on_red got %b want 0001", led_red); end
    n_vec++; if (led_blue !== 4'b0000) begin n_err++; $display("FAIL en_on_blue got %b want 0000", led_blue); end
    step_clk();
    step_clk();
    n_vec++; if (tone !== 1'b0) begin n_err++; $display("FAIL en_on_tone3 got %b want 0", tone); end
    step_clk();
    n_vec++; if (tone !== 1'b1) begin n_err++; $display("FAIL en_on_tone4 got %b want 1", tone); end
  endtask

  task automatic test_mode_step();
    int half;
    tick_in = ~tick_in;
    mode    = 2'b11;
    step_clk();
    n_vec++; if (phase !== 1'b0) begin n_err++; $display("FAIL ms_phase got %b want 0", phase); end
    n_vec++; if (led_red !== 4'b1111) begin n_err++; $display("FAIL ms_red got %b want 1111", led_red); end
    n_vec++; if (led_blue !== 4'b1111) begin n_err++; $display("FAIL ms_blue got %b want 1111", led_blue); end
    step_clk();
    n_vec++; if (phase !== 1'b0) begin n_err++; $display("FAIL ms_late got %b want 0", phase); end
    measure_half(half);
    n_vec++; if (half !== 4) begin n_err++; $display("FAIL ms_half got %0d want 4", half); end
  endtask

  task automatic test_reset_mid();
    int guard;
    mode    = 2'b01;
    tick_in = 1'b0;
    step_clk();
    tick_in = 1'b1;
    step_clk();
    n_vec++; if (phase !== 1'b1) begin n_err++; $display("FAIL rm_phaseB got %b want 1", phase); end
    guard = 0;
    while (tone !== 1'b1 && guard < 40) begin
      step_clk();
      guard++;
    end
    n_vec++; if (tone !== 1'b1) begin n_err++; $display("FAIL rm_tone_hi got %b want 1", tone); end
    rst     = 1'b1;
    tick_in = 1'b0;
    step_clk();
    n_vec++; if (led_red !== 4'b0000) begin n_err++; $display("FAIL rm_red got %b want 0000", led_red); end
    n_vec++; if (led_blue !== 4'b0000) begin n_err++; $display("FAIL rm_blue got %b want 0000", led_blue); end
    n_vec++; if (tone !== 1'b0) begin n_err++; $display("FAIL rm_tone got %b want 0", tone); end
    n_vec++; if (phase !== 1'b0) begin n_err++; $display("FAIL rm_phase got %b want 0", phase); end
    rst = 1'b0;
    step_clk();
    n_vec++; if (led_red !== 4'b1111) begin n_err++; $display("FAIL rm_post_red got %b want 1111", led_red); end
    repeat (3) step_clk();
    n_vec++; if (phase !== 1'b0) begin n_err++; $display("FAIL rm_nostep got %b want 0", phase); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; tick_in = 1'b1; mode = 2'b00;
    test_reset();
    test_alternate();
    test_chase();
    test_enable();
    test_mode_step();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
